// File: rtl/mm_sequencer.sv
// mm_sequencer: sequences one 3x3 matrix multiply through an external systolic array.
// Ports: clk, reset (sync, active-high); load_we/load_sel/load_addr/load_data write
// A (sel=0) or B (sel=1) elements row-major while idle; start/accum request a run;
// busy/done report progress; arr_clr clears the array; arr_a1..3 feed rows from the
// left edge and arr_b1..3 feed columns from the top edge, skewed one cycle per row/column.
// Optional macro MM_SEQ_ACCUM_EN: start with accum=1 skips the clear so the run adds A*B
// onto the existing array results.
module mm_sequencer #(
   parameter int data_size = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 load_we,
   input  logic                 load_sel,
   input  logic [3:0]           load_addr,
   input  logic [data_size-1:0] load_data,
   input  logic                 start,
   input  logic                 accum,
   output logic                 busy,
   output logic                 done,
   output logic                 arr_clr,
   output logic [data_size-1:0] arr_a1,
   output logic [data_size-1:0] arr_a2,
   output logic [data_size-1:0] arr_a3,
   output logic [data_size-1:0] arr_b1,
   output logic [data_size-1:0] arr_b2,
   output logic [data_size-1:0] arr_b3
);
   typedef enum logic [2:0] {IDLE, CLR, FEED, DRAIN, DONE} state_e;
   state_e               state_q, state_d;
   logic [2:0]           t_q, t_d;
   logic                 busy_q, busy_d, done_q, done_d, clr_q, clr_d;
   logic [data_size-1:0] mat_a_q [9];
   logic [data_size-1:0] mat_b_q [9];
   logic [data_size-1:0] fa_q [3];
   logic [data_size-1:0] fa_d [3];
   logic [data_size-1:0] fb_q [3];
   logic [data_size-1:0] fb_d [3];
   logic                 wr;
`ifndef MM_SEQ_ACCUM_EN
   logic                 unused_accum;
   assign unused_accum = accum;
`endif
   // a start in the same cycle wins over a write
   assign wr = (state_q == IDLE) && load_we && !start && (load_addr <= 4'd8);
   always_comb begin
      state_d = state_q;
      t_d     = t_q;
      case (state_q)
         IDLE: if (start) begin
            t_d = '0;
`ifdef MM_SEQ_ACCUM_EN
            state_d = accum ? FEED : CLR;
`else
            state_d = CLR;
`endif
         end
         CLR: begin
            state_d = FEED;
            t_d     = '0;
         end
         FEED: begin
            t_d     = t_q + 3'd1;
            state_d = (t_q == 3'd4) ? DRAIN : FEED;
         end
         DRAIN: begin
            t_d     = t_q + 3'd1;
            state_d = (t_q == 3'd6) ? DONE : DRAIN;
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end
   // outputs are computed from the next state so they appear registered in that state
   assign busy_d = (state_d == CLR) || (state_d == FEED) || (state_d == DRAIN);
   assign done_d = state_d == DONE;
   assign clr_d  = state_d == CLR;
   // row i sees A[i][t-i], column j sees B[t-j][j]; out-of-range terms are zero
   always_comb begin
      logic [2:0] k;
      for (int i = 0; i < 3; i++) begin
         k       = t_d - 3'(i);
         fa_d[i] = '0;
         fb_d[i] = '0;
         if ((state_d == FEED || state_d == DRAIN) && t_d >= 3'(i) && k <= 3'd2) begin
            fa_d[i] = mat_a_q[4'(3 * i) + {1'b0, k}];
            fb_d[i] = mat_b_q[4'(3 * k) + 4'(i)];
         end
      end
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         t_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         clr_q   <= 1'b0;
         for (int i = 0; i < 9; i++) begin
            mat_a_q[i] <= '0;
            mat_b_q[i] <= '0;
         end
         for (int i = 0; i < 3; i++) begin
            fa_q[i] <= '0;
            fb_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         t_q     <= t_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         clr_q   <= clr_d;
         fa_q    <= fa_d;
         fb_q    <= fb_d;
         if (wr && load_sel) mat_b_q[load_addr] <= load_data;
         if (wr && !load_sel) mat_a_q[load_addr] <= load_data;
      end
   end
   assign busy    = busy_q;
   assign done    = done_q;
   assign arr_clr = clr_q;
   assign arr_a1  = fa_q[0];
   assign arr_a2  = fa_q[1];
   assign arr_a3  = fa_q[2];
   assign arr_b1  = fb_q[0];
   assign arr_b2  = fb_q[1];
   assign arr_b3  = fb_q[2];
endmodule

// File: tb/tb_mm_sequencer.sv
// tb_mm_sequencer: drives mm_sequencer into a behavioural 3x3 systolic array and scoreboards results.
module tb_mm_sequencer;
   localparam int DW = 8;
   localparam int CW = 2 * DW + 1;
   typedef int vec9_t [9];
   typedef struct packed {
      logic [9*CW-1:0] c;
      int              cyc;
   } exp_t;

   logic          clk, reset, load_we, load_sel, start, accum;
   logic [3:0]    load_addr;
   logic [DW-1:0] load_data;
   logic          busy, done, arr_clr;
   logic [DW-1:0] arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3;

   mm_sequencer #(.data_size(DW)) dut (
      .clk(clk), .reset(reset), .load_we(load_we), .load_sel(load_sel),
      .load_addr(load_addr), .load_data(load_data), .start(start), .accum(accum),
      .busy(busy), .done(done), .arr_clr(arr_clr),
      .arr_a1(arr_a1), .arr_a2(arr_a2), .arr_a3(arr_a3),
      .arr_b1(arr_b1), .arr_b2(arr_b2), .arr_b3(arr_b3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // behavioural systolic array: a flows right, b flows down, each PE accumulates a*b
   logic [DW-1:0] fa [3];
   logic [DW-1:0] fb [3];
   logic [DW-1:0] ap [3][3];
   logic [DW-1:0] bp [3][3];
   logic [CW-1:0] acc [3][3];
   assign fa[0] = arr_a1;
   assign fa[1] = arr_a2;
   assign fa[2] = arr_a3;
   assign fb[0] = arr_b1;
   assign fb[1] = arr_b2;
   assign fb[2] = arr_b3;
   always @(posedge clk) begin : array_model
      logic [DW-1:0] ai, bi;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            if (j == 0) ai = fa[i];
            else ai = ap[i][j-1];
            if (i == 0) bi = fb[j];
            else bi = bp[i-1][j];
            if (arr_clr) begin
               acc[i][j] <= '0;
               ap[i][j]  <= '0;
               bp[i][j]  <= '0;
            end else begin
               acc[i][j] <= acc[i][j] + CW'(ai) * CW'(bi);
               ap[i][j]  <= ai;
               bp[i][j]  <= bi;
            end
         end
   end

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t q[$];
   exp_t mon_e;

   always @(negedge clk) begin
      if (done) begin
         if (q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done at cyc %0d got done=1 want done=0", cyc);
         end else begin
            mon_e = q.pop_front();
            n_tests++;
            if (cyc != mon_e.cyc) begin
               n_fail++;
               $display("FAIL done_latency got cyc %0d want cyc %0d", cyc, mon_e.cyc);
            end
            n_tests++;
            if (busy !== 1'b0) begin
               n_fail++;
               $display("FAIL busy_at_done got %b want 0", busy);
            end
            for (int k = 0; k < 9; k++) begin
               n_tests++;
               if (acc[k/3][k%3] !== mon_e.c[k*CW +: CW]) begin
                  n_fail++;
                  $display("FAIL c%0d got %0d want %0d", k + 1, acc[k/3][k%3], mon_e.c[k*CW +: CW]);
               end
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
      n_tests++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s got %0h want %0h", name, got, want);
      end
   endtask

   task automatic check_idle(input string name);
      check(name, {13'd0, busy, done, arr_clr, arr_a1, arr_a2, arr_a3, arr_b1, arr_b2, arr_b3}, 64'd0);
   endtask

   task automatic wait_drain();
      for (int k = 0; k < 20 && q.size() != 0; k++) @(negedge clk);
      @(negedge clk);
      n_tests++;
      if (q.size() != 0) begin
         n_fail++;
         $display("FAIL done_timeout got %0d pending want 0", q.size());
         q.delete();
      end
   endtask

   task automatic push(input vec9_t c, input int at);
      exp_t e;
      for (int k = 0; k < 9; k++) e.c[k*CW +: CW] = CW'(c[k]);
      e.cyc = at;
      q.push_back(e);
   endtask

   task automatic write_raw(input logic sel, input int addr, input int data);
      @(negedge clk);
      load_we   = 1'b1;
      load_sel  = sel;
      load_addr = 4'(addr);
      load_data = DW'(data);
      @(negedge clk);
      load_we = 1'b0;
   endtask

   task automatic load(input logic sel, input vec9_t m);
      for (int k = 0; k < 9; k++) write_raw(sel, k, m[k]);
   endtask

   // each run also attempts a colliding write to A[0] that must be dropped
   task automatic run(input vec9_t c, input logic acc_bit, input int lat);
      @(negedge clk);
      start     = 1'b1;
      accum     = acc_bit;
      load_we   = 1'b1;
      load_sel  = 1'b0;
      load_addr = 4'd0;
      load_data = 8'hAA;
      push(c, cyc + lat);
      @(negedge clk);
      start   = 1'b0;
      accum   = 1'b0;
      load_we = 1'b0;
      check("busy_first_cycle", {63'd0, busy}, 64'd1);
      check("clr_first_cycle", {63'd0, arr_clr}, {63'd0, lat == 9});
      wait_drain();
   endtask

   vec9_t id    = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
   vec9_t seq   = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
   vec9_t sq    = '{30, 36, 42, 66, 81, 96, 102, 126, 150};
   vec9_t full  = '{255, 255, 255, 255, 255, 255, 255, 255, 255};
   vec9_t wrap  = '{64003, 64003, 64003, 64003, 64003, 64003, 64003, 64003, 64003};
   vec9_t zeros = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
   vec9_t diag2 = '{2, 0, 0, 0, 2, 0, 0, 0, 2};

   initial begin
      int s;
      reset = 1'b1; load_we = 1'b0; load_sel = 1'b0; load_addr = '0;
      load_data = '0; start = 1'b0; accum = 1'b0;
      repeat (3) @(negedge clk);
      check_idle("reset_outputs");
      reset = 1'b0;
      @(negedge clk);
      check_idle("idle_after_reset");

      load(1'b0, id);
      load(1'b1, seq);
      write_raw(1'b0, 9, 77);
      write_raw(1'b0, 12, 77);
      run(seq, 1'b0, 9);

      load(1'b0, seq);
      run(sq, 1'b0, 9);

      // extra starts mid-run and on the done cycle, plus a write during FEED
      @(negedge clk);
      s = cyc;
      start = 1'b1;
      push(sq, s + 9);
      for (int k = 1; k <= 10; k++) begin
         @(negedge clk);
         start     = (k == 3) || (k == 9);
         load_we   = (k == 5);
         load_sel  = 1'b0;
         load_addr = 4'd4;
         load_data = 8'd99;
      end
      start   = 1'b0;
      load_we = 1'b0;
      wait_drain();
      repeat (12) @(negedge clk);
      check_idle("idle_after_ignored_starts");
      run(sq, 1'b0, 9);

      load(1'b0, full);
      load(1'b1, full);
      run(wrap, 1'b0, 9);

      // reset in the middle of FEED aborts the run and clears storage
      @(negedge clk);
      s = cyc;
      start = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         start = 1'b0;
         if (k == 5) reset = 1'b1;
      end
      check_idle("outputs_after_abort");
      reset = 1'b0;
      repeat (12) @(negedge clk);
      check_idle("idle_after_abort");
      run(zeros, 1'b0, 9);
      load(1'b0, seq);
      load(1'b1, seq);
      run(sq, 1'b0, 9);

      load(1'b0, id);
      load(1'b1, id);
`ifdef MM_SEQ_ACCUM_EN
      run(id, 1'b0, 9);
      run(diag2, 1'b1, 8);
`else
      run(id, 1'b0, 9);
      run(id, 1'b1, 9);
`endif

      repeat (4) @(negedge clk);
      check("queue_empty", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
